// File: rtl/pe_drain_writer.sv
// Drains one TxT accumulator tile from pe_array into the T BRAM C banks, one row per granted cycle.
// Optional macro PE_DRAIN_ACC_CLEAR_EN: pulse acc_clear in the first WRITE cycle.
module pe_drain_writer #(
    parameter int T      = 16,
    parameter int ACCW   = 32,
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [T*T*ACCW-1:0]       acc_mat,
    input  logic [T*T-1:0]            acc_v_mat,
    input  logic                      c_ready,
    output logic [T-1:0]              c_en,
    output logic [T-1:0]              c_we,
    output logic [T*ADDR_W-1:0]       c_addr,
    output logic [T*ACCW-1:0]         c_din,
    output logic [T*ACCW/8-1:0]       c_be,
    output logic                      busy,
    output logic                      done,
    output logic                      acc_clear,
    output logic                      err_invalid,
    output logic                      err_overrun,
    input  logic                      err_clr
);

    localparam int RW = (T > 1) ? $clog2(T) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(T - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [T*T*ACCW-1:0]   snap_q, snap_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_inv_q, err_inv_d;
    logic                  err_ovr_q, err_ovr_d;
    logic                  accept;
    logic                  wr;

    assign accept = (state_q == IDLE) && start;
    assign wr     = (state_q == WRITE) && c_ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        base_d  = base_q;
        snap_d  = snap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = acc_mat;
                    base_d  = base_addr;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (c_ready) begin
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A setting event in the same cycle as err_clr keeps the flag set.
    always_comb begin
        err_inv_d = err_clr ? 1'b0 : err_inv_q;
        err_ovr_d = err_clr ? 1'b0 : err_ovr_q;
        if (accept && !(&acc_v_mat)) begin
            err_inv_d = 1'b1;
        end
        if (start && (state_q != IDLE)) begin
            err_ovr_d = 1'b1;
        end
    end

    always_comb begin
        c_en   = '0;
        c_we   = '0;
        c_be   = '0;
        c_addr = '0;
        c_din  = '0;
        if (wr) begin
            c_en = '1;
            c_we = '1;
            c_be = '1;
            for (int j = 0; j < T; j++) begin
                c_addr[j*ADDR_W +: ADDR_W] = base_q + ADDR_W'(row_q);
                c_din[j*ACCW +: ACCW] = snap_q[(int'(row_q)*T + j)*ACCW +: ACCW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            base_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_inv_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            base_q    <= base_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_inv_q <= err_inv_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    // Snapshot contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

`ifdef PE_DRAIN_ACC_CLEAR_EN
    logic acc_clear_q, acc_clear_d;

    assign acc_clear_d = accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_clear_q <= 1'b0;
        end else begin
            acc_clear_q <= acc_clear_d;
        end
    end

    assign acc_clear = acc_clear_q;
`else
    assign acc_clear = 1'b0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_invalid = err_inv_q;
    assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_pe_drain_writer.sv
// Directed self-checking bench for pe_drain_writer (T=16, ACCW=32, ADDR_W=10).
module tb_pe_drain_writer;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [9:0]     base_addr;
    logic [8191:0]  acc_mat;
    logic [255:0]   acc_v_mat;
    logic           c_ready;
    logic [15:0]    c_en;
    logic [15:0]    c_we;
    logic [159:0]   c_addr;
    logic [511:0]   c_din;
    logic [63:0]    c_be;
    logic           busy;
    logic           done;
    logic           acc_clear;
    logic           err_invalid;
    logic           err_overrun;
    logic           err_clr;

    int n_assert = 0;
    int n_fail   = 0;

    int done_cyc;
    int rows;
    int bad;
    int stalls;
    int ac_hits;
    int ac_cyc;
    int seen_done;

    pe_drain_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .acc_mat    (acc_mat),
        .acc_v_mat  (acc_v_mat),
        .c_ready    (c_ready),
        .c_en       (c_en),
        .c_we       (c_we),
        .c_addr     (c_addr),
        .c_din      (c_din),
        .c_be       (c_be),
        .busy       (busy),
        .done       (done),
        .acc_clear  (acc_clear),
        .err_invalid(err_invalid),
        .err_overrun(err_overrun),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k, input int i, input int j);
        logic [31:0] r;
        case (k)
            0:       r = 32'(j);
            1:       r = 32'hA000_0000 + 32'(i * 256 + j);
            2:       r = 32'hDEAD_0000 ^ 32'(i * 16 + j);
            default: r = 32'h5555_0000 + 32'(i * 16 + j);
        endcase
        return r;
    endfunction

    task automatic load(input int k);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                acc_mat[(i*16+j)*32 +: 32] = pat(k, i, j);
    endtask

    // Cycle 0 is the cycle whose closing edge samples start.
    task automatic drain(input int k, input logic [9:0] base, input int slo,
                         input int shi, input int rs_cyc, input int rst_cyc);
        int c;
        logic [9:0] ea;
        done_cyc = -2;
        rows = 0; bad = 0; stalls = 0;
        ac_hits = 0; ac_cyc = -1; seen_done = 0;
        load(k);
        base_addr = base;
        c_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 10'h3ff;
        c = 1;
        while (c < 60) begin
            if (c == 1 && rs_cyc > 0) load(3);
            start = (c == rs_cyc);
            c_ready = !(c >= slo && c <= shi);
            if (c == rst_cyc) rst = 1'b1;
            #1;
            if (acc_clear) begin
                ac_hits++;
                ac_cyc = c;
            end
            if (c == rst_cyc) begin
                chk("rst_mid_out", {busy, done, acc_clear, c_en, c_we}, '0);
                done_cyc = -1;
                @(negedge clk);
                rst = 1'b0;
                for (int n = 0; n < 25; n++) begin
                    #1;
                    if (done) seen_done++;
                    @(negedge clk);
                end
                break;
            end
            if (done) begin
                done_cyc = c;
                if (!busy) bad++;
                break;
            end
            if (!busy) bad++;
            if (c_we == '0) begin
                stalls++;
                if (c_en != '0) bad++;
            end else begin
                if (c_we != '1 || c_en != '1 || c_be != '1) bad++;
                ea = base + 10'(rows);
                for (int j = 0; j < 16; j++) begin
                    if (c_addr[j*10 +: 10] !== ea) bad++;
                    if (c_din[j*32 +: 32] !== pat(k, rows, j)) bad++;
                end
                rows++;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        c_ready = 1'b1;
        if (rst_cyc == 0) begin
            @(negedge clk);
            #1;
            chk("idle_after_done", {busy, done, c_we}, '0);
        end
`ifdef PE_DRAIN_ACC_CLEAR_EN
        chk("acc_clear_hits", 64'(ac_hits), 64'd1);
        chk("acc_clear_cycle", 64'(ac_cyc), 64'd1);
`else
        chk("acc_clear_hits", 64'(ac_hits), 64'd0);
`endif
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        acc_mat = '0;
        acc_v_mat = '1;
        c_ready = 1'b1;
        err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_ctrl", {busy, done, acc_clear, err_invalid, err_overrun}, '0);
        chk("reset_we", {c_en, c_we}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Column-index tile, base 0, no stalls
        drain(0, 10'd0, 0, -1, 0, 0);
        chk("t1_done_cyc", 64'(done_cyc), 64'd17);
        chk("t1_rows", 64'(rows), 64'd16);
        chk("t1_bad", 64'(bad), 64'd0);
        chk("t1_stalls", 64'(stalls), 64'd0);
        chk("t1_errs", {err_invalid, err_overrun}, 2'b00);

        // Stall on cycles 3..5
        drain(1, 10'h155, 3, 5, 0, 0);
        chk("t2_done_cyc", 64'(done_cyc), 64'd20);
        chk("t2_rows", 64'(rows), 64'd16);
        chk("t2_stalls", 64'(stalls), 64'd3);
        chk("t2_bad", 64'(bad), 64'd0);

        // Address wrap from 1020
        drain(2, 10'd1020, 0, -1, 0, 0);
        chk("t3_done_cyc", 64'(done_cyc), 64'd17);
        chk("t3_rows", 64'(rows), 64'd16);
        chk("t3_bad", 64'(bad), 64'd0);

        // Invalid PE [5][7]
        acc_v_mat[5*16+7] = 1'b0;
        drain(1, 10'd7, 0, -1, 0, 0);
        acc_v_mat = '1;
        chk("t4_err_invalid", 64'(err_invalid), 64'd1);
        chk("t4_err_overrun", 64'(err_overrun), 64'd0);
        chk("t4_rows", 64'(rows), 64'd16);
        chk("t4_bad", 64'(bad), 64'd0);
        chk("t4_done_cyc", 64'(done_cyc), 64'd17);
        pulse_clr();
        chk("t4_err_clr", 64'(err_invalid), 64'd0);

        // Restart at cycle 6 with acc_mat changed after the snapshot
        drain(2, 10'd200, 0, -1, 6, 0);
        chk("t5_err_overrun", 64'(err_overrun), 64'd1);
        chk("t5_err_invalid", 64'(err_invalid), 64'd0);
        chk("t5_rows", 64'(rows), 64'd16);
        chk("t5_bad", 64'(bad), 64'd0);
        chk("t5_done_cyc", 64'(done_cyc), 64'd17);
        pulse_clr();
        chk("t5_err_clr", 64'(err_overrun), 64'd0);

        // Reset at cycle 8
        drain(0, 10'd40, 0, -1, 0, 8);
        chk("t6_rows", 64'(rows), 64'd7);
        chk("t6_no_done", 64'(seen_done), 64'd0);
        chk("t6_bad", 64'(bad), 64'd0);
        #1;
        chk("t6_idle", {busy, done, c_we, err_invalid, err_overrun}, '0);

        // Recovery after reset
        drain(3, 10'd5, 0, -1, 0, 0);
        chk("t7_done_cyc", 64'(done_cyc), 64'd17);
        chk("t7_rows", 64'(rows), 64'd16);
        chk("t7_bad", 64'(bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
